// File: rtl/axi4_burst_lite_bridge.sv
// AXI4 burst slave to single-beat lite master bridge; independent read and write FSMs.
// Optional address remap enabled by defining AXI_ADDR_REMAP_EN.
module axi4_burst_lite_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ID_W     = 4,
  parameter logic [3:0]  KEEP_NIB = 4'hA
) (
  input  logic                clock,
  input  logic                reset,
  // AXI4 write address
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  // AXI4 write data
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  // AXI4 write response
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  // AXI4 read address
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  // AXI4 read data
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  // lite master
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

`ifdef AXI_ADDR_REMAP_EN
  function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
    remap = (a[ADDR_W-1 -: 4] == KEEP_NIB) ? a : {4'h0, a[ADDR_W-5:0]};
  endfunction
`else
  logic unused_keep_nib;
  assign unused_keep_nib = ^KEEP_NIB;

  function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
    remap = a;
  endfunction
`endif

  // WRAP with an illegal length degrades to INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst,
                                                  input logic [7:0]        len);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] win;
    step = ADDR_W'(1) << size;
    win  = '0;
    case (len)
      8'd1:    win = step << 1;
      8'd3:    win = step << 2;
      8'd7:    win = step << 3;
      8'd15:   win = step << 4;
      default: win = '0;
    endcase
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (win == '0) ? a + step
                                       : (a & ~(win - 1'b1)) | ((a + step) & (win - 1'b1));
      default: next_addr = a + step;
    endcase
  endfunction

  // ---------------------------------------------------------------- read path
  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]        r_size_q, r_size_d;
  logic [1:0]        r_burst_q, r_burst_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_rvalid  = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          r_id_d    = s_arid;
          r_addr_d  = s_araddr;
          r_len_d   = s_arlen;
          r_size_d  = s_arsize;
          r_burst_d = s_arburst;
          r_beat_d  = '0;
          r_state_d = RAddr;
        end
      end
      RAddr: begin
        m_arvalid = 1'b1;
        if (m_arready) r_state_d = RData;
      end
      RData: begin
        m_rready = s_rready;
        s_rvalid = m_rvalid;
        if (m_rvalid && s_rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = RIdle;
          end else begin
            r_beat_d  = r_beat_q + 8'd1;
            r_addr_d  = next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
            r_state_d = RAddr;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign m_araddr = remap(r_addr_q);
  assign s_rid    = r_id_q;
  assign s_rdata  = m_rdata;
  assign s_rresp  = (r_size_q > MAX_SIZE) ? RESP_SLVERR : RESP_OKAY;
  assign s_rlast  = (r_beat_q == r_len_q);

  // --------------------------------------------------------------- write path
  typedef enum logic [2:0] {WIdle, WData, WIssue, WResp, WBresp} w_state_e;

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]        w_size_q, w_size_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic              w_err_q, w_err_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              aw_done_q, aw_done_d, wd_done_q, wd_done_d;
  logic              aw_ok, wd_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_done_q <= 1'b0;
      wd_done_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_done_q <= aw_done_d;
      wd_done_q <= wd_done_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_done_d = aw_done_q;
    wd_done_d = wd_done_q;
    aw_ok     = 1'b0;
    wd_ok     = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        s_awready = 1'b1;
        if (s_awvalid) begin
          w_id_d    = s_awid;
          w_addr_d  = s_awaddr;
          w_len_d   = s_awlen;
          w_size_d  = s_awsize;
          w_burst_d = s_awburst;
          w_beat_d  = '0;
          // Oversized beats are still performed but reported as SLVERR.
          w_err_d   = (s_awsize > MAX_SIZE);
          w_state_d = WData;
        end
      end
      WData: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          w_data_d  = s_wdata;
          w_strb_d  = s_wstrb;
          w_err_d   = w_err_q | (s_wlast != (w_beat_q == w_len_q));
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
          w_state_d = WIssue;
        end
      end
      WIssue: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !wd_done_q;
        aw_ok     = aw_done_q | m_awready;
        wd_ok     = wd_done_q | m_wready;
        aw_done_d = aw_ok;
        wd_done_d = wd_ok;
        if (aw_ok && wd_ok) w_state_d = WResp;
      end
      WResp: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          if (w_beat_q == w_len_q) begin
            w_state_d = WBresp;
          end else begin
            w_beat_d  = w_beat_q + 8'd1;
            w_addr_d  = next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
            w_state_d = WData;
          end
        end
      end
      WBresp: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign m_awaddr = remap(w_addr_q);
  assign m_wdata  = w_data_q;
  assign m_wstrb  = w_strb_q;
  assign s_bid    = w_id_q;
  assign s_bresp  = w_err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_burst_lite_bridge.sv
// Randomized scoreboard bench for axi4_burst_lite_bridge with a behavioural memory model.
module tb_axi4_burst_lite_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [3:0]  s_awid, s_bid, s_arid, s_rid, s_wstrb, m_wstrb;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  always #5 clock = ~clock;

  axi4_burst_lite_bridge dut (
    .clock(clock), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int r_beats  = 0;
  int cycle    = 0;
  int stall_until = 0;

  always @(posedge clock) cycle <= cycle + 1;

  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];   // {strb, data}
  logic [38:0] exp_r_q[$];   // {id, data, resp, last}
  logic [5:0]  exp_b_q[$];   // {id, resp}
  logic [31:0] shadow[logic [29:0]];
  logic [31:0] mem[logic [29:0]];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] rb_addr[$];
  logic [7:0]  rb_len[$];
  logic [2:0]  rb_size[$];
  logic [1:0]  rb_burst[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no event, required one within budget", name);
  endtask

  function automatic logic [31:0] model_remap(input logic [31:0] a);
`ifdef AXI_ADDR_REMAP_EN
    return (a[31:28] == 4'hA) ? a : (a & 32'h0FFF_FFFF);
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return ({wa, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return shadow.exists(a[31:2]) ? shadow[a[31:2]] : init_word(a[31:2]);
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : init_word(a[31:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Address of beat n computed directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int n);
    longint unsigned step, win, base, s;
    step = 64'd1 << size;
    s    = 64'(start);
    case (burst)
      2'b00: return start;
      2'b10: begin
        win  = (64'(len) + 64'd1) * step;
        base = s - (s % win);
        return 32'(base + ((s - base + longint'(n) * step) % win));
      end
      default: return 32'(s + longint'(n) * step);
    endcase
  endfunction

  task automatic issue_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] resp;
    int n;
    resp = (size > 3'd2) ? 2'b10 : 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      a = model_remap(beat_addr(addr, len, size, burst, i));
      exp_ar_q.push_back(a);
      exp_r_q.push_back({id, model_read(a), resp, (i == int'(len))});
    end
    @(posedge clock); #1;
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len;
    s_arsize = size; s_arburst = burst;
    n = 0;
    do begin @(negedge clock); n++; end while (!s_arready && n < 5000);
    if (!s_arready) fail_now("ar_accept_timeout");
    @(posedge clock); #1 s_arvalid = 1'b0;
  endtask

  task automatic issue_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit bad_last);
    logic [31:0] dv[$];
    logic [3:0]  sv[$];
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = model_remap(beat_addr(addr, len, size, burst, i));
      if (wd_q.size() != 0) begin d = wd_q.pop_front(); s = ws_q.pop_front(); end
      else begin d = $urandom; s = 4'($urandom_range(1, 15)); end
      dv.push_back(d); sv.push_back(s);
      exp_aw_q.push_back(a);
      exp_w_q.push_back({s, d});
      shadow[a[31:2]] = merge(model_read(a), d, s);
    end
    exp_b_q.push_back({id, (bad_last || size > 3'd2) ? 2'b10 : 2'b00});
    @(posedge clock); #1;
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len;
    s_awsize = size; s_awburst = burst;
    n = 0;
    do begin @(negedge clock); n++; end while (!s_awready && n < 5000);
    if (!s_awready) fail_now("aw_accept_timeout");
    @(posedge clock); #1 s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i != 0) begin @(posedge clock); #1; end
      s_wvalid = 1'b1; s_wdata = dv[i]; s_wstrb = sv[i];
      s_wlast = (i == int'(len)) ^ (bad_last && i == 0);
      n = 0;
      do begin @(negedge clock); n++; end while (!s_wready && n < 5000);
      if (!s_wready) fail_now("w_accept_timeout");
    end
    @(posedge clock); #1 s_wvalid = 1'b0;
  endtask

  task automatic flush_q();
    exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_r_q.delete(); exp_b_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_ar_q.size() + exp_r_q.size() + exp_aw_q.size() + exp_w_q.size() +
            exp_b_q.size()) != 0 && n < 20000) begin
      @(negedge clock); n++;
    end
    if (n >= 20000) begin fail_now("drain_timeout"); flush_q(); end
    repeat (2) @(negedge clock);
  endtask

  function automatic logic [7:0] wrap_len(input int k);
    case (k)
      0:       return 8'd1;
      1:       return 8'd3;
      2:       return 8'd7;
      default: return 8'd15;
    endcase
  endfunction

  // Memory model on the lite side with random ready/latency.
  initial begin : mem_slave
    logic [31:0] pend_ar, pend_aw, pend_wd;
    logic [3:0]  pend_ws;
    bit have_ar, have_aw, have_w, r_hs, b_hs, rst_seen;
    int rdel;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rdata = '0;
    have_ar = 0; have_aw = 0; have_w = 0; rdel = 0;
    pend_ar = '0; pend_aw = '0; pend_wd = '0; pend_ws = '0;
    forever begin
      @(negedge clock);
      rst_seen = reset;
      r_hs = m_rvalid && m_rready;
      b_hs = m_bvalid && m_bready;
      if (!reset) begin
        if (m_arvalid && m_arready) begin
          pend_ar = m_araddr; have_ar = 1; rdel = $urandom_range(0, 2);
        end
        if (m_awvalid && m_awready) begin pend_aw = m_awaddr; have_aw = 1; end
        if (m_wvalid && m_wready) begin pend_wd = m_wdata; pend_ws = m_wstrb; have_w = 1; end
      end
      @(posedge clock); #1;
      if (rst_seen) begin
        have_ar = 0; have_aw = 0; have_w = 0;
        m_rvalid = 0; m_bvalid = 0; m_arready = 0; m_awready = 0; m_wready = 0;
        continue;
      end
      if (r_hs) m_rvalid = 0;
      if (b_hs) m_bvalid = 0;
      if (have_ar && !m_rvalid) begin
        if (rdel == 0) begin m_rvalid = 1; m_rdata = slave_read(pend_ar); have_ar = 0; end
        else rdel--;
      end
      if (have_aw && have_w && !m_bvalid) begin
        mem[pend_aw[31:2]] = merge(slave_read(pend_aw), pend_wd, pend_ws);
        m_bvalid = 1; have_aw = 0; have_w = 0;
      end
      m_arready = 1'($urandom_range(0, 1));
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
    end
  end

  initial begin : s_ready_drv
    s_rready = 0; s_bready = 0;
    forever begin
      @(posedge clock); #1;
      s_rready = (cycle < stall_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
      s_bready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    logic [38:0] er;
    logic [35:0] ew;
    logic [5:0]  eb;
    bit prev_stall;
    logic [31:0] prev_data;
    prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin prev_stall = 0; continue; end
      if (m_arvalid && m_arready) begin
        if (exp_ar_q.size() == 0) fail_now("m_ar_unexpected");
        else check("m_araddr", m_araddr, exp_ar_q.pop_front());
      end
      if (m_awvalid && m_awready) begin
        if (exp_aw_q.size() == 0) fail_now("m_aw_unexpected");
        else check("m_awaddr", m_awaddr, exp_aw_q.pop_front());
      end
      if (m_wvalid && m_wready) begin
        if (exp_w_q.size() == 0) fail_now("m_w_unexpected");
        else begin
          ew = exp_w_q.pop_front();
          check("m_wdata", m_wdata, ew[31:0]);
          check("m_wstrb", m_wstrb, ew[35:32]);
        end
      end
      if (s_rvalid && s_rready) begin
        r_beats++;
        if (exp_r_q.size() == 0) fail_now("s_r_unexpected");
        else begin
          er = exp_r_q.pop_front();
          check("s_rid", s_rid, er[38:35]);
          check("s_rdata", s_rdata, er[34:3]);
          check("s_rresp", s_rresp, er[2:1]);
          check("s_rlast", s_rlast, er[0]);
        end
      end
      if (prev_stall) begin
        check("r_stall_valid", s_rvalid, 1'b1);
        check("r_stall_data", s_rdata, prev_data);
      end
      prev_stall = s_rvalid && !s_rready;
      if (prev_stall) begin
        check("m_rready_stall", m_rready, 1'b0);
        prev_data = s_rdata;
      end
      if (s_bvalid && s_bready) begin
        if (exp_b_q.size() == 0) fail_now("s_b_unexpected");
        else begin
          eb = exp_b_q.pop_front();
          check("s_bid", s_bid, eb[5:2]);
          check("s_bresp", s_bresp, eb[1:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int start;
    int n;
    reset = 1'b1;
    s_awvalid = 0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_wlast = 0;
    s_arvalid = 0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_s_arready", s_arready, 1'b1);
    check("rst_s_awready", s_awready, 1'b1);
    check("rst_s_wready", s_wready, 1'b0);
    check("rst_s_rvalid", s_rvalid, 1'b0);
    check("rst_s_bvalid", s_bvalid, 1'b0);
    check("rst_m_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b000);
    @(posedge clock); #1 reset = 1'b0;

    // Directed bursts
    issue_read(4'd3, 32'h8000_0000, 8'd0, 3'd2, 2'b01);
    issue_read(4'd1, 32'h8000_0000, 8'd3, 3'd2, 2'b01);
    issue_read(4'd2, 32'h8000_0008, 8'd3, 3'd2, 2'b10);
    wd_q = '{32'hAABB_CCDD, 32'h1122_3344};
    ws_q = '{4'hF, 4'h3};
    issue_write(4'd5, 32'h8000_0010, 8'd1, 3'd2, 2'b01, 1'b0);
    drain();
    issue_read(4'd6, 32'h8000_0010, 8'd1, 3'd2, 2'b01);
    issue_write(4'd7, 32'h8000_0020, 8'd1, 3'd2, 2'b01, 1'b1);
    issue_read(4'd4, 32'hA000_0010, 8'd3, 3'd2, 2'b01);
    stall_until = cycle + 6;
    issue_read(4'd8, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01);
    issue_read(4'd9, 32'h8000_0040, 8'd2, 3'd2, 2'b00);
    issue_read(4'd10, 32'h8000_0100, 8'd1, 3'd3, 2'b01);
    issue_read(4'd11, 32'h8000_0060, 8'd2, 3'd2, 2'b11);
    issue_write(4'd12, 32'h8000_0200, 8'd0, 3'd3, 2'b01, 1'b0);
    issue_write(4'd13, 32'h8000_0300, 8'd0, 3'd2, 2'b01, 1'b1);
    issue_read(4'd14, 32'h8000_0400, 8'd255, 3'd2, 2'b01);
    drain();

    // Concurrent random reads and writes on disjoint regions
    fork
      for (int i = 0; i < 30; i++) begin
        logic [1:0] b; logic [2:0] sz; logic [7:0] ln; logic [31:0] ad;
        b  = 2'($urandom_range(0, 3));
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        ln = (b == 2'b10) ? wrap_len($urandom_range(0, 3)) : 8'($urandom_range(0, 15));
        ad = (32'h8000_0000 + ($urandom_range(0, 255) << 2)) & ~((32'd1 << sz) - 32'd1);
        issue_read(4'($urandom), ad, ln, sz, b);
      end
      for (int i = 0; i < 30; i++) begin
        logic [1:0] b; logic [2:0] sz; logic [7:0] ln; logic [31:0] ad;
        b  = 2'($urandom_range(0, 3));
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        ln = (b == 2'b10) ? wrap_len($urandom_range(0, 3)) : 8'($urandom_range(0, 15));
        ad = (32'h8000_8000 + ($urandom_range(0, 255) << 2)) & ~((32'd1 << sz) - 32'd1);
        rb_addr.push_back(ad); rb_len.push_back(ln); rb_size.push_back(sz); rb_burst.push_back(b);
        issue_write(4'($urandom), ad, ln, sz, b, ($urandom_range(0, 7) == 0));
      end
    join
    drain();

    // Read back what the random writes left in memory
    for (int i = 0; i < rb_addr.size(); i++)
      issue_read(4'(i), rb_addr[i], rb_len[i], rb_size[i], rb_burst[i]);
    drain();

    // Reset in the middle of a len=7 read
    start = r_beats;
    issue_read(4'd13, 32'h8000_0500, 8'd7, 3'd2, 2'b01);
    n = 0;
    while (r_beats < start + 2 && n < 5000) begin @(negedge clock); n++; end
    if (r_beats < start + 2) fail_now("mid_burst_beats_timeout");
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("midrst_s_rvalid", s_rvalid, 1'b0);
    check("midrst_m_arvalid", m_arvalid, 1'b0);
    check("midrst_s_arready", s_arready, 1'b1);
    flush_q();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    start = r_beats;
    issue_read(4'd14, 32'h8000_0600, 8'd0, 3'd2, 2'b01);
    drain();
    check("post_rst_read_beats", r_beats - start, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
